// File: rtl/mac3_pkg.sv
// mac3_pkg: shared definitions for the 3-sample multiply-add unit.
//   DW_DEFAULT : default data width of data_in / data_out
//   state_t    : run-length FSM states (IDLE, ONE, TWO, RUN)
//   SAT_FILL   : saturation constant fill bit; a saturated result is this bit
//                replicated across the data width (all-ones)
package mac3_pkg;

  localparam int DW_DEFAULT = 32;

  // Encodes how many consecutive validi cycles have been seen (RUN = 3 or more).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic SAT_FILL = 1'b1;

endpackage

// File: rtl/mac3_arith.sv
// mac3_arith: combinational multiply-add, result = a*b + c.
//   a, b, c : operands (DW bits each)
//   result  : low DW bits of the exact sum, or all-ones when saturated
//   ovf     : exact sum exceeded 2^DW-1 (saturating build only, else 0)
// Build option: define MAC3_SAT_EN to saturate instead of wrapping.
module mac3_arith
  import mac3_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] result,
  output logic          ovf
);

  // 2*DW+1 bits holds the largest possible a*b + c without loss.
  localparam int FW = 2 * DW + 1;

  logic [FW-1:0] full;

  assign full = FW'(a) * FW'(b) + FW'(c);

`ifdef MAC3_SAT_EN
  logic hi_nz;

  assign hi_nz  = |full[FW-1:DW];
  assign ovf    = hi_nz;
  assign result = hi_nz ? {DW{SAT_FILL}} : full[DW-1:0];
`else
  // Upper bits are discarded: the result wraps modulo 2^DW.
  logic unused_hi;

  assign unused_hi = ^full[FW-1:DW];
  assign result    = full[DW-1:0];
  assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/mac3_unit.sv
// mac3_unit: sliding 3-sample multiply-add, data_out = d[n-2]*d[n-1] + d[n].
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset; also forces data_out to 0
//   validi   : data_in qualifier
//   data_in  : operand sample (DW bits)
//   valido   : data_out holds a new result this cycle
//   data_out : multiply-add result, held while valido=0
//   ovf      : saturation flag, qualified by valido
// Build option: define MAC3_SAT_EN to saturate results above 2^DW-1.
module mac3_unit
  import mac3_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          validi,
  input  logic [DW-1:0] data_in,
  output logic          valido,
  output logic [DW-1:0] data_out,
  output logic          ovf
);

  state_t        state;
  state_t        state_nxt;

  // Window: two_back / one_back are registered; data_in is the present sample.
  logic [DW-1:0] two_back;
  logic [DW-1:0] one_back;

  logic          fire;
  logic [DW-1:0] arith_result;
  logic          arith_ovf;

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          ovf_q;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch is inferred.
    state_nxt = state;
    if (!validi) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ONE;
        ONE:     state_nxt = TWO;
        TWO:     state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A result is due when the present sample completes a run of three or more.
  assign fire = validi && ((state == TWO) || (state == RUN));

  mac3_arith #(
    .DW (DW)
  ) u_arith (
    .a      (two_back),
    .b      (one_back),
    .c      (data_in),
    .result (arith_result),
    .ovf    (arith_ovf)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      two_back <= '0;
      one_back <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= fire;
      ovf_q   <= fire && arith_ovf;
      if (validi) begin
        two_back <= one_back;
        one_back <= data_in;
      end
      if (fire) begin
        data_q <= arith_result;
      end
    end
  end

  assign valido   = valid_q;
  assign ovf      = ovf_q;
  // Reset blanks the output immediately, not only after the next edge.
  assign data_out = rst ? '0 : data_q;

endmodule
